rsa_modexp: RTL and testbench
=============================

RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; Montgomery radix R = 2^WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ena  input  1  clock enable; when low, all registers hold.
REQ-005 SHALL have port start_cmd  input  1  one-cycle start pulse.
REQ-006 SHALL have port stop_cmd  input  1  one-cycle abort pulse.
REQ-007 SHALL have port p  input  WIDTH  modulus P; must be odd.
REQ-008 SHALL have port e  input  WIDTH  exponent E.
REQ-009 SHALL have port m  input  WIDTH  message M; must satisfy M < P.
REQ-010 SHALL have port r2const  input  WIDTH  precomputed value R^2 mod P.
REQ-011 SHALL have port c  output  WIDTH  result C = M^E mod P; held until the next completion.
REQ-012 SHALL have port eoc  output  1  end-of-computation pulse.
REQ-013 SHALL have port busy  output  1  high while a computation is in progress.

Function
REQ-014 SHALL compute C = M^E mod P by left-to-right square-and-multiply over Montgomery products.
REQ-015 SHALL define MonPro(a,b) = a*b*R^-1 mod P, computed bit-serially over WIDTH iteration cycles plus 1 correction cycle (WIDTH+1 cycles total).
- Each iteration i: t = t + a[i]*b; if t is odd, t = t + P; then t = t >> 1.
- Correction cycle: if t >= P, t = t - P.
REQ-016 SHALL size the accumulator t at WIDTH+2 bits; no intermediate overflow is permitted.
REQ-017 SHALL latch p, e, m and r2const on the enabled edge that samples start_cmd while idle; later changes on these inputs SHALL NOT affect the running computation.
REQ-018 SHALL sequence through states IDLE -> MBAR -> XBAR -> SQR -> (MUL if the current e bit is 1) -> back to SQR for the next lower bit -> FINAL -> IDLE.
- MBAR: m_bar = MonPro(M, r2const).
- XBAR: x = MonPro(1, r2const).
- SQR: x = MonPro(x, x).
- MUL: x = MonPro(m_bar, x).
- FINAL: result = MonPro(x, 1).
REQ-019 SHALL process e bits from WIDTH-1 down to 0, always processing all WIDTH bits, including leading zeros.
REQ-020 SHALL use N = 3 + WIDTH + popcount(E) MonPro operations per computation.
REQ-021 SHALL update c and pulse eoc for exactly one cycle, both visible exactly N*(WIDTH+1) enabled cycles after the edge that sampled start_cmd.
REQ-022 SHALL make c valid in the same cycle that eoc is high.
REQ-023 SHALL drive busy high from the cycle after start is accepted through the cycle before eoc; busy SHALL be low in the eoc cycle.
REQ-024 SHALL ignore start_cmd while busy.
REQ-025 SHALL, on stop_cmd while busy, return to IDLE on the next enabled edge, with busy low, no eoc, and c unchanged.
REQ-026 SHALL treat stop_cmd while idle as having no effect.
REQ-027 SHALL give stop_cmd priority when start_cmd and stop_cmd are asserted in the same cycle: no computation starts.
REQ-028 SHALL give stop_cmd priority when it arrives in the final FINAL cycle: abort, no eoc.
REQ-029 SHALL freeze state, counters, busy, c and eoc while ena is low; the total latency SHALL extend by exactly the number of disabled cycles.
REQ-030 SHALL, for even P or M >= P, produce an unspecified c but still complete with the REQ-021 latency and return to IDLE.

Reset
REQ-031 SHALL, on rst high, asynchronously force state IDLE, c = 0, eoc = 0, busy = 0 and all internal registers to 0, regardless of ena.
REQ-032 SHALL, on rst mid-computation, discard the computation; no eoc SHALL follow the release of reset.
REQ-033 SHALL, after rst deasserts, accept start_cmd on the first enabled edge.

Verification (WIDTH = 8)
REQ-034 SHALL cover: P=13, r2const=3, M=4, E=3 -> c=12, eoc pulse 117 cycles after start, busy high for 116 cycles.
REQ-035 SHALL cover: P=13, r2const=3, M=4, E=0 -> c=1, eoc 99 cycles after start.
REQ-036 SHALL cover: P=251, r2const=25, M=2, E=255 -> c=32, eoc 171 cycles after start.
REQ-037 SHALL cover: complete the REQ-034 case, start a new run, pulse stop_cmd at cycle 50 -> busy low next cycle, no eoc within 300 cycles, c remains 12; a second start_cmd pulsed in the same cycle as the stop_cmd pulse is ignored.
REQ-038 SHALL cover: REQ-034 run with ena low for 10 cycles at cycle 40 -> c=12, eoc at cycle 127.
REQ-039 SHALL cover: REQ-034 run with rst pulsed at cycle 60 -> c=0, busy=0 immediately, no eoc afterwards; a new start then yields c=12 after 117 cycles.

Source files
------------

// File: rtl/rsa_modexp.sv
// Montgomery square-and-multiply modular exponentiator, C = M^E mod P, one bit-serial MonPro at a time.
// Latency (3 + WIDTH + popcount(E)) * (WIDTH+1) enabled cycles; stop_cmd aborts at once, start_cmd ignored while running.
module rsa_modexp #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start_cmd,
   input  logic             stop_cmd,
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] m,
   input  logic [WIDTH-1:0] r2const,
   output logic [WIDTH-1:0] c,
   output logic             eoc,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    CYC_LAST = CW'(WIDTH);
   localparam logic [BW-1:0]    BIT_TOP  = BW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_MBAR, S_XBAR, S_SQR, S_MUL, S_FINAL} state_t;

   state_t           state;
   logic [CW-1:0]    cyc;
   logic [BW-1:0]    bitcnt;
   logic [WIDTH-1:0] p_r, e_r, m_r, r2_r, mbar, x;
   logic [WIDTH+1:0] t;

   logic [WIDTH-1:0] opa, opb, t_red;
   logic [WIDTH+1:0] p_ext, t_add, t_odd;
   logic             a_bit, e_bit;

   // Operand pair for the MonPro of the current state
   always_comb begin
      opa = '0;
      opb = '0;
      case (state)
         S_MBAR:  begin opa = m_r;  opb = r2_r; end
         S_XBAR:  begin opa = ONE;  opb = r2_r; end
         S_SQR:   begin opa = x;    opb = x;    end
         S_MUL:   begin opa = mbar; opb = x;    end
         S_FINAL: begin opa = x;    opb = ONE;  end
         default: ;
      endcase
   end

   assign a_bit = 1'(opa >> cyc);
   assign e_bit = 1'(e_r >> bitcnt);
   assign p_ext = {2'b00, p_r};
   assign t_add = a_bit ? t + {2'b00, opb} : t;
   assign t_odd = t_add[0] ? t_add + p_ext : t_add;
   assign t_red = (t >= p_ext) ? WIDTH'(t - p_ext) : WIDTH'(t);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cyc    <= '0;
         bitcnt <= '0;
         p_r    <= '0;
         e_r    <= '0;
         m_r    <= '0;
         r2_r   <= '0;
         mbar   <= '0;
         x      <= '0;
         t      <= '0;
         c      <= '0;
         eoc    <= 1'b0;
         busy   <= 1'b0;
      end else if (ena) begin
         eoc <= 1'b0;
         if (state == S_IDLE) begin
            if (start_cmd && !stop_cmd) begin
               p_r   <= p;
               e_r   <= e;
               m_r   <= m;
               r2_r  <= r2const;
               t     <= '0;
               cyc   <= '0;
               state <= S_MBAR;
            end
         end else if (stop_cmd) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cyc   <= '0;
            t     <= '0;
         end else begin
            busy <= 1'b1;
            if (cyc != CYC_LAST) begin
               t   <= t_odd >> 1;
               cyc <= cyc + 1'b1;
            end else begin
               // Correction cycle: store the reduced product and pick the next operation
               t   <= '0;
               cyc <= '0;
               case (state)
                  S_MBAR: begin
                     mbar  <= t_red;
                     state <= S_XBAR;
                  end
                  S_XBAR: begin
                     x      <= t_red;
                     bitcnt <= BIT_TOP;
                     state  <= S_SQR;
                  end
                  S_SQR: begin
                     x <= t_red;
                     if (e_bit)
                        state <= S_MUL;
                     else if (bitcnt == '0)
                        state <= S_FINAL;
                     else
                        bitcnt <= bitcnt - 1'b1;
                  end
                  S_MUL: begin
                     x <= t_red;
                     if (bitcnt == '0) begin
                        state <= S_FINAL;
                     end else begin
                        bitcnt <= bitcnt - 1'b1;
                        state  <= S_SQR;
                     end
                  end
                  S_FINAL: begin
                     c     <= t_red;
                     eoc   <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_rsa_modexp.sv
// Bench for rsa_modexp (WIDTH=8): arithmetic reference model with a countdown of remaining cycles.
module tb_rsa_modexp;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b1;
   logic       start_cmd = 1'b0;
   logic       stop_cmd = 1'b0;
   logic [7:0] p = 8'd0, e = 8'd0, m = 8'd0, r2const = 8'd0;
   logic [7:0] c;
   logic       eoc, busy;

   always #5 clk = ~clk;

   rsa_modexp #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .ena(ena), .start_cmd(start_cmd), .stop_cmd(stop_cmd),
      .p(p), .e(e), .m(m), .r2const(r2const), .c(c), .eoc(eoc), .busy(busy)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   function automatic int modexp(input int mm, input int ee, input int pp);
      int r = 1 % pp;
      for (int i = 0; i < ee; i++) r = (r * mm) % pp;
      return r;
   endfunction

   function automatic int lat_of(input logic [7:0] ee);
      return (3 + 8 + $countones(ee)) * 9;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: cycles remaining until completion, 0 when idle
   int         rem = 0;
   logic [7:0] exp_c = 8'd0, pend_c = 8'd0;
   logic       exp_eoc = 1'b0, exp_busy = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rem      <= 0;
         exp_c    <= 8'd0;
         exp_eoc  <= 1'b0;
         exp_busy <= 1'b0;
      end else if (ena) begin
         exp_eoc <= 1'b0;
         if (rem == 0) begin
            if (start_cmd && !stop_cmd) begin
               rem    <= lat_of(e);
               pend_c <= 8'(modexp(int'(m), int'(e), int'(p)));
            end
         end else if (stop_cmd) begin
            rem      <= 0;
            exp_busy <= 1'b0;
         end else if (rem == 1) begin
            rem      <= 0;
            exp_c    <= pend_c;
            exp_eoc  <= 1'b1;
            exp_busy <= 1'b0;
         end else begin
            rem      <= rem - 1;
            exp_busy <= 1'b1;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
         tests++;
         if (c !== exp_c || eoc !== exp_eoc || busy !== exp_busy) begin
            fails++;
            $display("FAIL cycle t=%0t c=%0d req %0d eoc=%b req %b busy=%b req %b",
                     $time, c, exp_c, eoc, exp_eoc, busy, exp_busy);
         end
      end
   end

   // One run: pulse start, then step edge by edge with optional stop/disable/reset events
   task automatic run(input logic [7:0] pp, input logic [7:0] r2, input logic [7:0] mm,
                      input logic [7:0] ee, input int limit, input int stop_at,
                      input int dis_from, input int dis_len, input int rst_at,
                      output int lat, output int bcnt);
      @(negedge clk);
      p = pp; r2const = r2; m = mm; e = ee; start_cmd = 1'b1;
      @(negedge clk);
      start_cmd = 1'b0;
      p = pp ^ 8'h5A; m = mm ^ 8'h33; e = ee ^ 8'hC3; r2const = r2 ^ 8'h0F;
      lat = -1;
      bcnt = 0;
      for (int cnt = 1; cnt <= limit; cnt++) begin
         ena       = !(cnt >= dis_from && cnt < dis_from + dis_len);
         stop_cmd  = (cnt == stop_at);
         start_cmd = (cnt == stop_at);
         rst       = (cnt == rst_at);
         if (cnt == rst_at) begin
            #1;
            chk("rst_mid_c", int'(c), 0);
            chk("rst_mid_busy", int'(busy), 0);
         end
         @(posedge clk);
         #1;
         if (busy) bcnt++;
         if (cnt == stop_at) chk("stop_busy_next", int'(busy), 0);
         if (eoc && lat < 0) lat = cnt;
         if (eoc) break;
         @(negedge clk);
      end
      ena = 1'b1; stop_cmd = 1'b0; start_cmd = 1'b0; rst = 1'b0;
   endtask

   initial begin
      int lat, bc, seen;
      #2 rst = 1'b1;
      @(negedge clk);
      chk("reset_c", int'(c), 0);
      chk("reset_eoc", int'(eoc), 0);
      chk("reset_busy", int'(busy), 0);

      chk("model_4_3_13", modexp(4, 3, 13), 12);
      chk("model_4_0_13", modexp(4, 0, 13), 1);
      chk("model_2_255_251", modexp(2, 255, 251), 32);
      chk("model_lat_e3", lat_of(8'd3), 117);
      chk("model_lat_e255", lat_of(8'd255), 171);

      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      run(8'd13, 8'd3, 8'd4, 8'd3, 400, -1, -1, 0, -1, lat, bc);
      chk("e3_c", int'(c), 12);
      chk("e3_latency", lat, 117);
      chk("e3_busy_cycles", bc, 116);

      run(8'd13, 8'd3, 8'd4, 8'd0, 400, -1, -1, 0, -1, lat, bc);
      chk("e0_c", int'(c), 1);
      chk("e0_latency", lat, 99);

      run(8'd251, 8'd25, 8'd2, 8'd255, 400, -1, -1, 0, -1, lat, bc);
      chk("e255_c", int'(c), 32);
      chk("e255_latency", lat, 171);

      run(8'd13, 8'd3, 8'd4, 8'd3, 400, -1, -1, 0, -1, lat, bc);
      chk("rerun_c", int'(c), 12);

      run(8'd13, 8'd3, 8'd4, 8'd3, 350, 50, -1, 0, -1, lat, bc);
      chk("stop_no_eoc", lat, -1);
      chk("stop_c_held", int'(c), 12);
      chk("stop_busy_cycles", bc, 49);

      // start and stop together while idle: nothing may start
      @(negedge clk);
      start_cmd = 1'b1; stop_cmd = 1'b1;
      @(negedge clk);
      start_cmd = 1'b0; stop_cmd = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (busy || eoc) seen = 1;
      end
      chk("idle_start_stop", seen, 0);

      run(8'd13, 8'd3, 8'd4, 8'd3, 400, -1, 40, 10, -1, lat, bc);
      chk("ena_gap_c", int'(c), 12);
      chk("ena_gap_latency", lat, 127);

      run(8'd13, 8'd3, 8'd4, 8'd3, 300, -1, -1, 0, 60, lat, bc);
      chk("rst_no_eoc", lat, -1);
      chk("rst_c_cleared", int'(c), 0);

      run(8'd13, 8'd3, 8'd4, 8'd3, 400, -1, -1, 0, -1, lat, bc);
      chk("post_rst_c", int'(c), 12);
      chk("post_rst_latency", lat, 117);

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
